obstacle_field: RTL and testbench

//  Game-state and obstacle engine directly upstream of the VGA renderer.
//  - Owns the N_BARS scrolling pipes: position, pseudo-random gap centre, respawn.
//  - Detects bird/pipe/floor collision and keeps the score.
//  - Runs the IDLE/PLAY/DEAD game FSM.
//  - All motion advances once per video frame, derived from vsync.

---
 rtl/flappy_pkg.sv | 41 ++++
 rtl/lfsr16.sv | 22 ++
 rtl/obstacle_field.sv | 169 ++++++++++++++++
 tb/tb_obstacle_field.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared constants, types and helpers for the flappy obstacle engine.
package flappy_pkg;

  localparam int N_BARS    = 4;
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int BAR_W     = 40;
  localparam int GAP_H     = 80;
  localparam int SPACING   = 180;
  localparam int SPEED     = 2;
  localparam int GAP_MIN   = 60;
  localparam int GAP_MAX   = 420;
  localparam int DEAD_HOLD = 30;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois toggle mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } game_state_t;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  gap;
  } bar_t;

  // Parked position of pipe i: just off the right edge, SPACING apart
  function automatic logic [10:0] bar_home(input int i);
    return 11'(SCREEN_W + BAR_W + i * SPACING);
  endfunction

  // Forces a raw 9-bit random value into the legal gap-centre window
  function automatic logic [9:0] clamp_gap(input logic [8:0] raw);
    if ({1'b0, raw} < 10'(GAP_MIN)) return 10'(GAP_MIN);
    if ({1'b0, raw} > 10'(GAP_MAX)) return 10'(GAP_MAX);
    return {1'b0, raw};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR used as the gap-centre random source.
module lfsr16
  import flappy_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] state
);

  // Shift right, folding the outgoing bit back through the tap mask
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state <= SEED;
    end else if (en) begin
      state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/obstacle_field.sv
// Scrolling pipes, bird collision, score keeping and the IDLE/PLAY/DEAD game FSM.
// Motion advances once per video frame on the synchronised vsync falling edge.
module obstacle_field
  import flappy_pkg::*;
(
  input  logic                     clk_100MHz,
  input  logic                     reset,
  input  logic                     vsync,
  input  logic                     flap,
  input  logic [9:0]               bird_x,
  input  logic [9:0]               bird_y,
  input  logic [3:0]               bird_w,
  input  logic [3:0]               bird_h,
  output logic [N_BARS-1:0][10:0]  bar_x,
  output logic [N_BARS-1:0][9:0]   gap_y,
  output logic [7:0]               score,
  output logic                     playing,
  output logic                     game_over,
  output logic                     frame_tick
);

  localparam logic [10:0]        SPEED_X    = 11'(SPEED);
  localparam logic [10:0]        RESPAWN_X  = 11'(N_BARS * SPACING - SPEED);
  localparam logic [9:0]         HOME_GAP   = 10'(SCREEN_H / 2);
  localparam logic signed [11:0] BAR_W_S    = 12'(BAR_W);
  localparam logic signed [11:0] HALF_GAP_S = 12'(GAP_H / 2);
  localparam logic signed [11:0] SCREEN_H_S = 12'(SCREEN_H);
  localparam logic [4:0]         HOLD_MAX   = 5'(DEAD_HOLD);

  function automatic logic [7:0] sat_add(input logic [7:0] s, input logic [2:0] inc);
    logic [8:0] sum;
    sum = {1'b0, s} + {6'b0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  logic               vsync_s1, vsync_s2, vsync_d;
  logic               flap_s1, flap_s2, flap_d, flap_evt;
  logic [15:0]        lfsr_state;
  logic [9:0]         gap_cand;
  logic               unused_lfsr_hi;
  game_state_t        state, state_nx;
  logic [4:0]         hold_cnt;
  logic signed [11:0] half_w, half_h;
  logic signed [11:0] bird_left_s, bird_right_s, bird_top_s, bird_bot_s;
  logic [10:0]        bird_left_u;
  logic [N_BARS-1:0]  hit_bar, passed;
  logic               hit;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .en         (1'b1),
    .state      (lfsr_state)
  );

  assign gap_cand       = clamp_gap(lfsr_state[8:0]);
  assign unused_lfsr_hi = ^lfsr_state[15:9];

  // Two-flop synchronisers plus a delay stage for edge detection; vsync idles high
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      vsync_s1   <= 1'b1;
      vsync_s2   <= 1'b1;
      vsync_d    <= 1'b1;
      flap_s1    <= 1'b0;
      flap_s2    <= 1'b0;
      flap_d     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vsync_s1   <= vsync;
      vsync_s2   <= vsync_s1;
      vsync_d    <= vsync_s2;
      flap_s1    <= flap;
      flap_s2    <= flap_s1;
      flap_d     <= flap_s2;
      frame_tick <= vsync_d & ~vsync_s2;
    end
  end

  assign flap_evt = flap_s2 & ~flap_d;

  // Bird bounding box in 12-bit signed space so edges near zero never wrap
  assign half_w       = $signed({8'b0, bird_w}) >>> 1;
  assign half_h       = $signed({8'b0, bird_h}) >>> 1;
  assign bird_left_s  = $signed({2'b00, bird_x}) - half_w;
  assign bird_right_s = $signed({2'b00, bird_x}) + half_w;
  assign bird_top_s   = $signed({2'b00, bird_y}) - half_h;
  assign bird_bot_s   = $signed({2'b00, bird_y}) + half_h;
  assign bird_left_u  = bird_left_s[11] ? 11'd0 : bird_left_s[10:0];

  for (genvar i = 0; i < N_BARS; i++) begin : g_bar
    localparam bar_t HOME = '{x: bar_home(i), gap: HOME_GAP};
    bar_t               cur;
    logic               respawn;
    logic [10:0]        nxt_x;
    logic [9:0]         nxt_gap;
    logic signed [11:0] right_s, gap_s;

    assign respawn = (cur.x <= SPEED_X);
    assign nxt_x   = respawn ? cur.x + RESPAWN_X : cur.x - SPEED_X;
    assign nxt_gap = respawn ? gap_cand : cur.gap;

    // A pipe is passed when its right edge crosses the bird's left edge this frame
    assign passed[i] = (cur.x >= bird_left_u) && (nxt_x < bird_left_u);

    assign right_s    = $signed({1'b0, cur.x});
    assign gap_s      = $signed({2'b00, cur.gap});
    assign hit_bar[i] = (bird_left_s < right_s) && (bird_right_s > right_s - BAR_W_S) &&
                        ((bird_top_s < gap_s - HALF_GAP_S) || (bird_bot_s > gap_s + HALF_GAP_S));

    // Pipe register: parked in IDLE, scrolls/respawns each PLAY frame, frozen in DEAD
    always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
        cur <= HOME;
      end else if (state == IDLE) begin
        cur <= HOME;
      end else if (state == PLAY && frame_tick) begin
        cur <= '{x: nxt_x, gap: nxt_gap};
      end
    end

    assign bar_x[i] = cur.x;
    assign gap_y[i] = cur.gap;
  end

  assign hit = (|hit_bar) || (bird_bot_s >= SCREEN_H_S) || (bird_top_s < 12'sd0);

  // Game FSM transitions; flap is ignored while playing
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (flap_evt) state_nx = PLAY;
      PLAY:    if (frame_tick && hit) state_nx = DEAD;
      DEAD:    if (flap_evt && hold_cnt >= HOLD_MAX) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, status flags and the DEAD hold counter
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      playing   <= 1'b0;
      game_over <= 1'b0;
      hold_cnt  <= 5'd0;
    end else begin
      state     <= state_nx;
      playing   <= (state_nx == PLAY);
      game_over <= (state_nx == DEAD);
      if (state != DEAD) begin
        hold_cnt <= 5'd0;
      end else if (frame_tick && hold_cnt < HOLD_MAX) begin
        hold_cnt <= hold_cnt + 5'd1;
      end
    end
  end

  // Score: cleared in IDLE, counts passed pipes on PLAY frames (including the fatal one)
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      score <= 8'd0;
    end else if (state == IDLE) begin
      score <= 8'd0;
    end else if (state == PLAY && frame_tick) begin
      score <= sat_add(score, 3'($countones(passed)));
    end
  end

endmodule

// File: tb/tb_obstacle_field.sv
// Scoreboard bench for obstacle_field: a frame-level game model predicts the scene
// after every frame_tick; a monitor pops and compares when the DUT pulses frame_tick.
`timescale 1ns/1ps
module tb_obstacle_field;
  import flappy_pkg::*;

  logic                    clk_100MHz = 1'b0;
  logic                    reset = 1'b1;
  logic                    vsync = 1'b1;
  logic                    flap = 1'b0;
  logic [9:0]              bird_x = 10'd100;
  logic [9:0]              bird_y = 10'd240;
  logic [3:0]              bird_w = 4'd10;
  logic [3:0]              bird_h = 4'd10;
  logic [N_BARS-1:0][10:0] bar_x;
  logic [N_BARS-1:0][9:0]  gap_y;
  logic [7:0]              score;
  logic                    playing, game_over, frame_tick;

  obstacle_field dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .vsync      (vsync),
    .flap       (flap),
    .bird_x     (bird_x),
    .bird_y     (bird_y),
    .bird_w     (bird_w),
    .bird_h     (bird_h),
    .bar_x      (bar_x),
    .gap_y      (gap_y),
    .score      (score),
    .playing    (playing),
    .game_over  (game_over),
    .frame_tick (frame_tick)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct packed {
    logic [N_BARS-1:0][10:0] bx;
    logic [N_BARS-1:0][9:0]  gy;
    logic [7:0]              sc;
    logic                    pl;
    logic                    go;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          tick_seq = 0;
  logic [15:0] tick_lfsr = 16'h0;

  // Frame-level game model: 0 = idle, 1 = playing, 2 = dead
  int m_bx[N_BARS];
  int m_gy[N_BARS];
  int m_score, m_state, m_hold;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Free-running reference random source, one step per clock since reset
  logic [15:0] m_lfsr;
  always @(posedge clk_100MHz or posedge reset) begin
    if (reset) m_lfsr <= LFSR_SEED;
    else       m_lfsr <= lfsr_next(m_lfsr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic int home_x(input int i);
    return SCREEN_W + BAR_W + i * SPACING;
  endfunction

  function automatic int clamp_model(input int g);
    if (g < GAP_MIN) return GAP_MIN;
    if (g > GAP_MAX) return GAP_MAX;
    return g;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N_BARS; i++) begin
      m_bx[i] = home_x(i);
      m_gy[i] = SCREEN_H / 2;
    end
    m_score = 0;
    m_state = 0;
    m_hold  = 0;
  endtask

  function automatic bit model_hit();
    int l, r, t, b;
    l = int'(bird_x) - int'(bird_w) / 2;
    r = int'(bird_x) + int'(bird_w) / 2;
    t = int'(bird_y) - int'(bird_h) / 2;
    b = int'(bird_y) + int'(bird_h) / 2;
    if (b >= SCREEN_H || t < 0) return 1'b1;
    for (int i = 0; i < N_BARS; i++)
      if (l < m_bx[i] && r > m_bx[i] - BAR_W &&
          (t < m_gy[i] - GAP_H / 2 || b > m_gy[i] + GAP_H / 2)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_expected();
    exp_t e;
    for (int i = 0; i < N_BARS; i++) begin
      e.bx[i] = 11'(m_bx[i]);
      e.gy[i] = 10'(m_gy[i]);
    end
    e.sc = 8'(m_score);
    e.pl = (m_state == 1);
    e.go = (m_state == 2);
    exp_q.push_back(e);
  endtask

  task automatic model_tick();
    int  l, old, nb;
    bit  h;
    if (m_state == 1) begin
      h = model_hit();
      l = int'(bird_x) - int'(bird_w) / 2;
      if (l < 0) l = 0;
      for (int i = 0; i < N_BARS; i++) begin
        old = m_bx[i];
        if (old <= SPEED) begin
          nb = old + N_BARS * SPACING - SPEED;
          m_gy[i] = clamp_model(int'(tick_lfsr[8:0]));
        end else begin
          nb = old - SPEED;
        end
        if (old >= l && nb < l && m_score < 255) m_score++;
        m_bx[i] = nb;
      end
      if (h) begin
        m_state = 2;
        m_hold  = 0;
      end
    end else if (m_state == 2) begin
      if (m_hold < DEAD_HOLD) m_hold++;
    end
    push_expected();
  endtask

  task automatic do_frame();
    int seq0, n;
    seq0 = tick_seq;
    n = 0;
    @(negedge clk_100MHz);
    vsync = 1'b0;
    while (tick_seq == seq0 && n < 40) begin
      @(posedge clk_100MHz);
      n++;
    end
    if (tick_seq == seq0) begin
      checks++;
      errors++;
      $display("FAIL frame_tick_timeout: no frame_tick within %0d cycles", n);
    end else begin
      model_tick();
    end
    @(negedge clk_100MHz);
    vsync = 1'b1;
    repeat ($urandom_range(4, 9)) @(negedge clk_100MHz);
  endtask

  task automatic do_flap();
    @(negedge clk_100MHz);
    flap = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    flap = 1'b0;
    repeat (4) @(negedge clk_100MHz);
    if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 2 && m_hold >= DEAD_HOLD) begin
      m_reset();
    end
    check("playing_after_flap", playing, m_state == 1);
    check("game_over_after_flap", game_over, m_state == 2);
  endtask

  task automatic set_bird_safe();
    int best, tgt;
    bird_x = 10'd100;
    bird_w = 4'd10;
    best = 4096;
    tgt = SCREEN_H / 2;
    for (int i = 0; i < N_BARS; i++)
      if (m_bx[i] > 95 && m_bx[i] < best) begin
        best = m_bx[i];
        tgt  = m_gy[i];
      end
    bird_h = 4'($urandom_range(0, 15));
    bird_y = 10'(tgt + int'($urandom_range(0, 60)) - 30);
  endtask

  task automatic set_bird_random();
    bird_x = 10'($urandom_range(0, 1023));
    bird_y = 10'($urandom_range(0, 520));
    bird_w = 4'($urandom_range(0, 15));
    bird_h = 4'($urandom_range(0, 15));
  endtask

  task automatic check_home(input string tag);
    for (int i = 0; i < N_BARS; i++) begin
      check($sformatf("%s_bar_x[%0d]", tag, i), bar_x[i], home_x(i));
      check($sformatf("%s_gap_y[%0d]", tag, i), gap_y[i], SCREEN_H / 2);
    end
    check({tag, "_score"}, score, 0);
    check({tag, "_playing"}, playing, 0);
    check({tag, "_game_over"}, game_over, 0);
    check({tag, "_frame_tick"}, frame_tick, 0);
  endtask

  // Monitor: on each frame_tick, compare the updated scene with the oldest prediction
  initial begin : monitor
    exp_t                    e;
    logic [N_BARS-1:0][10:0] prev;
    int                      ups;
    forever begin
      @(negedge clk_100MHz);
      if (frame_tick === 1'b1) begin
        tick_lfsr = m_lfsr;
        prev = bar_x;
        tick_seq++;
        @(negedge clk_100MHz);
        check("frame_tick_width", frame_tick, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: frame_tick with no prediction, got 0 expected 1");
        end else begin
          e = exp_q.pop_front();
          ups = 0;
          for (int i = 0; i < N_BARS; i++) begin
            check($sformatf("bar_x[%0d]", i), bar_x[i], e.bx[i]);
            check($sformatf("gap_y[%0d]", i), gap_y[i], e.gy[i]);
            if (bar_x[i] > prev[i]) ups++;
          end
          check("respawns_per_tick", ups <= 1, 1);
          check("score", score, e.sc);
          check("playing", playing, e.pl);
          check("game_over", game_over, e.go);
        end
      end
    end
  end

  initial begin : stimulus
    int ov;
    m_reset();
    repeat (4) @(negedge clk_100MHz);
    check_home("reset");
    reset = 1'b0;

    // Idle frames: scene stays parked
    repeat (3) begin
      set_bird_safe();
      do_frame();
    end

    // Start and fly safely through scoring and respawns
    do_flap();
    repeat (420) begin
      set_bird_safe();
      do_frame();
    end

    // Steer the bird outside the gap of an overlapping pipe
    for (int k = 0; k < 200 && m_state == 1; k++) begin
      ov = -1;
      for (int i = 0; i < N_BARS; i++)
        if (95 < m_bx[i] && 105 > m_bx[i] - BAR_W) ov = i;
      if (ov >= 0) begin
        bird_x = 10'd100;
        bird_w = 4'd10;
        bird_h = 4'd10;
        bird_y = 10'((m_gy[ov] >= 240) ? m_gy[ov] - 60 : m_gy[ov] + 60);
      end else begin
        set_bird_safe();
      end
      do_frame();
    end
    check("game_over_after_hit", game_over, 1);
    check("playing_after_hit", playing, 0);

    // Dead: early restart refused, late restart accepted
    repeat (10) begin
      set_bird_random();
      do_frame();
    end
    do_flap();
    check("early_flap_still_dead", game_over, 1);
    repeat (21) begin
      set_bird_random();
      do_frame();
    end
    do_flap();
    check("restart_playing", playing, 0);
    check("restart_game_over", game_over, 0);
    check("restart_score", score, 0);
    repeat (2) begin
      set_bird_safe();
      do_frame();
    end

    // Reset in the middle of a game
    do_flap();
    repeat (20) begin
      set_bird_safe();
      do_frame();
    end
    @(negedge clk_100MHz);
    reset = 1'b1;
    #1;
    check_home("midreset");
    repeat (2) @(negedge clk_100MHz);
    reset = 1'b0;
    m_reset();
    repeat (2) begin
      set_bird_safe();
      do_frame();
    end

    // Fully random bird against the model
    do_flap();
    repeat (60) begin
      set_bird_random();
      do_frame();
    end

    repeat (5) @(negedge clk_100MHz);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
